// File: rtl/pattern_pkg.sv
// Shared encodings for the test pattern generator: pattern modes,
// pixel handshake states and the colour sweep sub-states.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_CHECKER  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    HS_IDLE      = 3'd0,
    HS_ISSUE     = 3'd1,
    HS_WAIT_ACK  = 3'd2,
    HS_WAIT_DONE = 3'd3,
    HS_ADVANCE   = 3'd4
  } hs_state_t;

  typedef enum logic [1:0] {
    SW_BLUE  = 2'd0,
    SW_GREEN = 2'd1,
    SW_RED   = 2'd2,
    SW_ALL   = 2'd3
  } sweep_t;

  // Scale a coordinate onto a channel range and clamp at the channel maximum.
  function automatic int unsigned scale_sat(input int unsigned coord, input int unsigned bits,
                                            input int unsigned log2_span);
    int unsigned v;
    int unsigned vmax;
    vmax = (32'd1 << bits) - 32'd1;
    v    = (coord << bits) >> log2_span;
    if (v > vmax) v = vmax;
    return v;
  endfunction

endpackage

// File: rtl/pixel_scanner.sv
// Raster position and frame counting for the pattern generator.
// Exposes the post-advance position so colour for the next pixel can be
// computed in the same cycle the position moves.
module pixel_scanner #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = $clog2(WIDTH) + 1,
  parameter int YW     = $clog2(HEIGHT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic [7:0]    next_frame,
  output logic          wrap,
  output logic          frame_done
);

  logic [7:0] frame;
  logic       last_x;
  logic       last_y;

  // Next raster position; the frame counter wraps naturally at 8 bits.
  always_comb begin
    last_x     = (x == XW'(WIDTH - 1));
    last_y     = (y == YW'(HEIGHT - 1));
    wrap       = advance && last_x && last_y;
    next_x     = x;
    next_y     = y;
    next_frame = frame;
    if (advance) begin
      if (last_x) begin
        next_x = '0;
        if (last_y) begin
          next_y     = '0;
          next_frame = frame + 8'd1;
        end else begin
          next_y = y + YW'(1);
        end
      end else begin
        next_x = x + XW'(1);
      end
    end
  end

  // Position/frame registers; frame_done pulses the cycle after the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      x          <= next_x;
      y          <= next_y;
      frame      <= next_frame;
      frame_done <= wrap;
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator feeding a pixel-at-a-time LCD driver through a
// WRITE_EN / IS_BUSY handshake.
//
// state        | meaning
// HS_IDLE      | parked; waits for LCD_READY, ENABLE and an idle driver
// HS_ISSUE     | WRITE_EN high for this single cycle
// HS_WAIT_ACK  | waits for the driver to raise IS_BUSY, bounded by a timer
// HS_WAIT_DONE | waits for the driver to drop IS_BUSY
// HS_ADVANCE   | moves to the next pixel and registers its colour
module test_pattern_gen
  import pattern_pkg::*;
#(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int R_BITS      = 5,
  parameter int G_BITS      = 6,
  parameter int B_BITS      = 5,
  parameter int CHECK_LOG2  = 3,
  parameter int ACK_TIMEOUT = 1024,
  localparam int PW = R_BITS + G_BITS + B_BITS,
  localparam int XW = $clog2(WIDTH) + 1,
  localparam int YW = $clog2(HEIGHT) + 1
) (
  input  logic          SYSTEM_CLK,
  input  logic          RST,
  input  logic          LCD_READY,
  input  logic          IS_BUSY,
  input  logic          ENABLE,
  input  logic [1:0]    MODE,
  output logic          WRITE_EN,
  output logic [PW-1:0] COLOR_PIXEL,
  output logic [XW-1:0] COLOR_X,
  output logic [YW-1:0] COLOR_Y,
  output logic          FRAME_DONE,
  output logic          ACK_ERR
);

  localparam int TW     = $clog2(ACK_TIMEOUT + 1);
  localparam int XLOG   = $clog2(WIDTH);
  localparam int YLOG   = $clog2(HEIGHT);
  localparam int FSHIFT = (B_BITS >= 8) ? 0 : 8 - B_BITS;
  localparam logic [R_BITS-1:0] R_MAX = {R_BITS{1'b1}};
  localparam logic [G_BITS-1:0] G_MAX = {G_BITS{1'b1}};
  localparam logic [B_BITS-1:0] B_MAX = {B_BITS{1'b1}};

  hs_state_t         state, state_n;
  logic [TW-1:0]     timer;
  logic              advance;
  logic              timeout;
  mode_t             mode_q;
  mode_t             eff_mode;

  logic [XW-1:0]     next_x;
  logic [YW-1:0]     next_y;
  logic [7:0]        next_frame;
  logic              wrap;

  sweep_t            sw_sub, sw_sub_n;
  logic [R_BITS-1:0] sw_r, sw_r_n;
  logic [G_BITS-1:0] sw_g, sw_g_n;
  logic [B_BITS-1:0] sw_b, sw_b_n;

  int unsigned       xe, ye, fe, bar, chk_bit;
  logic [R_BITS-1:0] ch_r;
  logic [G_BITS-1:0] ch_g;
  logic [B_BITS-1:0] ch_b;

  pixel_scanner #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_scanner (
    .clk        (SYSTEM_CLK),
    .rst        (RST),
    .advance    (advance),
    .x          (COLOR_X),
    .y          (COLOR_Y),
    .next_x     (next_x),
    .next_y     (next_y),
    .next_frame (next_frame),
    .wrap       (wrap),
    .frame_done (FRAME_DONE)
  );

  // Handshake state register.
  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) state <= HS_IDLE;
    else     state <= state_n;
  end

  // Handshake next-state and per-state strobes.
  always_comb begin
    state_n = state;
    advance = 1'b0;
    timeout = 1'b0;
    case (state)
      HS_IDLE:      if (LCD_READY && ENABLE && !IS_BUSY) state_n = HS_ISSUE;
      HS_ISSUE:     state_n = HS_WAIT_ACK;
      HS_WAIT_ACK: begin
        if (IS_BUSY) begin
          state_n = HS_WAIT_DONE;
        end else if (timer == '0) begin
          timeout = 1'b1;
          state_n = HS_ISSUE;
        end
      end
      HS_WAIT_DONE: if (!IS_BUSY) state_n = HS_ADVANCE;
      HS_ADVANCE: begin
        advance = 1'b1;
        state_n = ENABLE ? HS_ISSUE : HS_IDLE;
      end
      default:      state_n = HS_IDLE;
    endcase
  end

  assign WRITE_EN = (state == HS_ISSUE);

  // Acknowledge timer reloads on every issue; timeout fires once it has
  // run out and the driver still has not responded.
  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
    end else if (state == HS_ISSUE) begin
      timer <= TW'(ACK_TIMEOUT);
    end else if (state == HS_WAIT_ACK && timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  // Sticky handshake error and frame-start mode latch.
  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      ACK_ERR <= 1'b0;
      mode_q  <= MODE_SWEEP;
    end else begin
      if (timeout) ACK_ERR <= 1'b1;
      if (state == HS_ISSUE && COLOR_X == '0 && COLOR_Y == '0) mode_q <= mode_t'(MODE);
    end
  end

  // Sweep colour for the next frame; a channel reaching max hands over to
  // the next sub-state, which takes its first step in the same frame.
  always_comb begin
    sw_sub_n = sw_sub;
    sw_r_n   = sw_r;
    sw_g_n   = sw_g;
    sw_b_n   = sw_b;
    if (wrap) begin
      case (sw_sub)
        SW_BLUE: begin
          if (sw_b == B_MAX) begin
            sw_b_n   = '0;
            sw_g_n   = G_BITS'(1);
            sw_sub_n = SW_GREEN;
          end else begin
            sw_b_n = sw_b + B_BITS'(1);
          end
        end
        SW_GREEN: begin
          if (sw_g == G_MAX) begin
            sw_g_n   = '0;
            sw_r_n   = R_BITS'(1);
            sw_sub_n = SW_RED;
          end else begin
            sw_g_n = sw_g + G_BITS'(1);
          end
        end
        SW_RED: begin
          if (sw_r == R_MAX) begin
            sw_r_n   = R_BITS'(1);
            sw_g_n   = G_BITS'(1);
            sw_b_n   = B_BITS'(1);
            sw_sub_n = SW_ALL;
          end else begin
            sw_r_n = sw_r + R_BITS'(1);
          end
        end
        default: begin
          if (sw_r == R_MAX && sw_g == G_MAX && sw_b == B_MAX) begin
            sw_r_n   = '0;
            sw_g_n   = '0;
            sw_b_n   = '0;
            sw_sub_n = SW_BLUE;
          end else begin
            if (sw_r != R_MAX) sw_r_n = sw_r + R_BITS'(1);
            if (sw_g != G_MAX) sw_g_n = sw_g + G_BITS'(1);
            if (sw_b != B_MAX) sw_b_n = sw_b + B_BITS'(1);
          end
        end
      endcase
    end
  end

  // Sweep state register.
  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      sw_sub <= SW_BLUE;
      sw_r   <= '0;
      sw_g   <= '0;
      sw_b   <= '0;
    end else begin
      sw_sub <= sw_sub_n;
      sw_r   <= sw_r_n;
      sw_g   <= sw_g_n;
      sw_b   <= sw_b_n;
    end
  end

  // Colour of the pixel being advanced to. At a frame wrap the mode that
  // is about to be latched is used so pixel (0,0) already follows it.
  always_comb begin
    eff_mode = wrap ? mode_t'(MODE) : mode_q;
    xe       = 32'(next_x);
    ye       = 32'(next_y);
    fe       = 32'(next_frame);
    bar      = (xe * 32'd8) >> XLOG;
    if (bar > 32'd7) bar = 32'd7;
    chk_bit  = ((xe >> CHECK_LOG2) ^ (ye >> CHECK_LOG2) ^ fe) & 32'd1;
    ch_r     = '0;
    ch_g     = '0;
    ch_b     = '0;
    case (eff_mode)
      MODE_SWEEP: begin
        ch_r = sw_r_n;
        ch_g = sw_g_n;
        ch_b = sw_b_n;
      end
      MODE_BARS: begin
        ch_r = bar[2] ? R_MAX : R_BITS'(0);
        ch_g = bar[1] ? G_MAX : G_BITS'(0);
        ch_b = bar[0] ? B_MAX : B_BITS'(0);
      end
      MODE_GRADIENT: begin
        ch_r = R_BITS'(scale_sat(xe, R_BITS, XLOG));
        ch_g = G_BITS'(scale_sat(ye, G_BITS, YLOG));
        ch_b = B_BITS'(fe >> FSHIFT);
      end
      default: begin
        ch_r = (chk_bit != 0) ? R_MAX : R_BITS'(0);
        ch_g = (chk_bit != 0) ? G_MAX : G_BITS'(0);
        ch_b = (chk_bit != 0) ? B_MAX : B_BITS'(0);
      end
    endcase
  end

  // Pixel colour register, loaded as the position advances.
  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST)          COLOR_PIXEL <= '0;
    else if (advance) COLOR_PIXEL <= {ch_r, ch_g, ch_b};
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen on a 4x2 raster with a driver
// model that stays busy for three cycles per pixel.
module tb_test_pattern_gen;

  localparam int W = 4;
  localparam int H = 2;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_ready;
  logic        enable;
  logic [1:0]  mode;
  logic        is_busy = 1'b0;
  logic        write_en;
  logic [15:0] color;
  logic [2:0]  cx;
  logic [1:0]  cy;
  logic        frame_done;
  logic        ack_err;

  logic        drv_ack = 1'b1;
  int          busy_cnt = 0;

  typedef struct {
    int idx;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t sb[$];
  int   fd_q[$];
  int   wr_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   base;
  time  t0, t1;
  int   iv;

  test_pattern_gen #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .R_BITS      (5),
    .G_BITS      (6),
    .B_BITS      (5),
    .CHECK_LOG2  (3),
    .ACK_TIMEOUT (T)
  ) dut (
    .SYSTEM_CLK  (clk),
    .RST         (rst),
    .LCD_READY   (lcd_ready),
    .IS_BUSY     (is_busy),
    .ENABLE      (enable),
    .MODE        (mode),
    .WRITE_EN    (write_en),
    .COLOR_PIXEL (color),
    .COLOR_X     (cx),
    .COLOR_Y     (cy),
    .FRAME_DONE  (frame_done),
    .ACK_ERR     (ack_err)
  );

  always #5 clk = ~clk;

  // Driver model: acknowledges a write on the following cycle, busy 3 cycles.
  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) is_busy <= 1'b0;
    end else if (write_en && drv_ack) begin
      is_busy  <= 1'b1;
      busy_cnt <= 3;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int idx, input int k, input int c);
    exp_t e;
    e.idx = idx;
    e.x   = k % W;
    e.y   = k / W;
    e.c   = c;
    sb.push_back(e);
  endtask

  task automatic wait_wr(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (wr_cnt < n && cyc < budget) begin
      tick();
      cyc++;
    end
    if (wr_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL wait_wr: got %0d writes required %0d", wr_cnt, n);
    end
  endtask

  task automatic wait_busy(input int budget);
    int cyc;
    cyc = 0;
    while (!is_busy && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!is_busy) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: got is_busy=0 required 1");
    end
  endtask

  task automatic release_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: compares each presented write against the scoreboard head.
  initial begin
    exp_t e;
    int   fexp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done && fd_q.size() > 0) begin
          fexp = fd_q.pop_front();
          chk("frame_done_at_write", wr_cnt, fexp);
        end
        if (write_en) begin
          while (sb.size() > 0 && sb[0].idx < wr_cnt) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_write: got none at idx %0d required idx %0d", wr_cnt, e.idx);
          end
          if (sb.size() > 0 && sb[0].idx == wr_cnt) begin
            e = sb.pop_front();
            chk($sformatf("x[%0d]", e.idx), 32'(cx), e.x);
            chk($sformatf("y[%0d]", e.idx), 32'(cy), e.y);
            chk($sformatf("color[%0d]", e.idx), 32'(color), e.c);
          end
          wr_cnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gexp [8];
    int bars [4];
    bars[0] = 'h0000; bars[1] = 'h07E0; bars[2] = 'hF800; bars[3] = 'hFFE0;
    gexp[0] = 'h0000; gexp[1] = 'h4000; gexp[2] = 'h8000; gexp[3] = 'hC000;
    gexp[4] = 'h0400; gexp[5] = 'h4400; gexp[6] = 'h8400; gexp[7] = 'hC400;

    rst = 1'b1; lcd_ready = 1'b1; enable = 1'b1; mode = 2'd0;
    tick();
    tick();
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_color", 32'(color), 0);
    chk("rst_x", 32'(cx), 0);
    chk("rst_y", 32'(cy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_ack_err", 32'(ack_err), 0);

    // Sweep across a full ramp cycle.
    base = wr_cnt;
    for (int k = 0; k < 8; k++) push_px(base + k, k, 'h0000);
    push_px(base + 1*8 + 0, 0, 'h0001);
    push_px(base + 31*8 + 5, 5, 'h001F);
    push_px(base + 32*8 + 0, 0, 'h0020);
    push_px(base + 94*8 + 3, 3, 'h07E0);
    push_px(base + 95*8 + 0, 0, 'h0800);
    push_px(base + 125*8 + 7, 7, 'hF800);
    push_px(base + 126*8 + 2, 2, 'h0821);
    push_px(base + 188*8 + 7, 7, 'hFFFF);
    push_px(base + 189*8 + 0, 0, 'h0000);
    push_px(base + 189*8 + 1, 1, 'h0000);
    fd_q.push_back(base + 8);
    fd_q.push_back(base + 16);
    release_reset();
    wait_wr(base + 189*8 + 2, 20000);

    // Reset mid-handshake, then bars / checker / gradient sequence.
    wait_busy(50);
    mode = 2'd1;
    rst  = 1'b1;
    tick();
    chk("abort_write_en", 32'(write_en), 0);
    chk("abort_x", 32'(cx), 0);
    base = wr_cnt;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) push_px(base + f*8 + k, k, bars[k % 4]);
    for (int k = 0; k < 8; k++) push_px(base + 16 + k, k, 'h0000);
    for (int k = 0; k < 8; k++) push_px(base + 24 + k, k, 'hFFFF);
    for (int k = 0; k < 8; k++) push_px(base + 32 + k, k, gexp[k]);
    push_px(base + 64 + 0, 0, 'h0001);
    push_px(base + 64 + 7, 7, 'hC401);
    release_reset();
    wait_wr(base + 11, 400);
    mode = 2'd3;
    wait_wr(base + 25, 400);
    mode = 2'd2;
    wait_wr(base + 72, 2000);

    // Enable dropped while (1,1) is in flight.
    rst = 1'b1; mode = 2'd0;
    tick();
    base = wr_cnt;
    for (int k = 0; k < 6; k++) push_px(base + k, k, 'h0000);
    release_reset();
    wait_wr(base + 6, 400);
    wait_busy(50);
    enable = 1'b0;
    repeat (40) tick();
    chk("disabled_no_write", wr_cnt, base + 6);
    chk("parked_x", 32'(cx), 2);
    chk("parked_y", 32'(cy), 1);
    push_px(base + 6, 6, 'h0000);
    push_px(base + 7, 7, 'h0000);
    fd_q.push_back(base + 8);
    enable = 1'b1;
    wait_wr(base + 9, 400);

    // Driver that never acknowledges.
    drv_ack = 1'b0;
    rst = 1'b1;
    tick();
    base = wr_cnt;
    push_px(base + 0, 0, 'h0000);
    push_px(base + 1, 0, 'h0000);
    push_px(base + 2, 0, 'h0000);
    push_px(base + 3, 1, 'h0000);
    release_reset();
    wait_wr(base + 1, 100);
    t0 = $time;
    repeat (3) tick();
    chk("ack_err_before_timeout", 32'(ack_err), 0);
    wait_wr(base + 2, 200);
    t1 = $time;
    drv_ack = 1'b1;
    iv = int'((t1 - t0) / 10);
    chk("timeout_interval_in_range", 32'((iv >= T && iv <= T + 3) ? 1 : 0), 1);
    chk("ack_err_after_timeout", 32'(ack_err), 1);
    wait_wr(base + 4, 400);
    chk("ack_err_sticky", 32'(ack_err), 1);

    rst = 1'b1;
    tick();
    chk("ack_err_cleared_by_reset", 32'(ack_err), 0);
    rst = 1'b0;
    tick();

    chk("scoreboard_drained", sb.size(), 0);
    chk("frame_done_drained", fd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
